// File: rtl/fp16_to_fp32_rr_arbiter.sv
// fp16_to_fp32_rr_arbiter: round-robin shares one fp16->fp32 converter between NUM_REQ requesters,
// returning a registered, requester-tagged fp32 result on a single valid/ready port.
module fp16_to_fp32_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [16*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_out_valid,
  output logic [31:0]           o_out_data,
  output logic [ID_W-1:0]       o_out_id,
  input  logic                  i_out_ready,
  output logic [CNT_W-1:0]      o_conv_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            r_state, w_state_nxt;
  logic [31:0]       r_data;
  logic [ID_W-1:0]   r_id, r_last, w_gnt, w_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_any, w_can_load, w_load;
  logic [15:0]       w_sel;
  logic [31:0]       w_conv;

  function automatic logic [31:0] f16_to_f32(input logic [15:0] h);
    logic [4:0] e;
    logic [9:0] m, mn;
    logic [3:0] sh;
    e  = h[14:10];
    m  = h[9:0];
    sh = 4'd0;
    // highest set bit wins: shift that brings it to bit 10
    for (int i = 0; i < 10; i++)
      if (m[i]) sh = 4'(10 - i);
    mn = m << sh;
    return (e == 5'd0) ? ((m == 10'd0) ? {h[15], 31'b0} : {h[15], 8'(113 - int'(sh)), mn, 13'b0}) :
           (e == 5'd31) ? {h[15], 8'hFF, m, 13'b0} :
           {h[15], 8'({3'b0, e}) + 8'd112, m, 13'b0};
  endfunction

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    // walk downward so the nearest requester after r_last is the final assignment
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_can_load = (r_state == EMPTY) | i_out_ready;
  assign w_load     = w_can_load & w_any & ~i_reset;
  assign w_sel      = i_req_data[16*w_gnt +: 16];
  assign w_conv     = f16_to_f32(w_sel);

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    w_state_nxt = w_load ? FULL : (w_can_load ? EMPTY : r_state);
    o_req_ready = w_load ? (NUM_REQ'(1) << w_gnt) : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= w_conv;
        r_id   <= w_gnt;
        r_last <= w_gnt;
      end
      if (r_state == FULL && i_out_ready) r_cnt <= r_cnt + CNT_W'(1);
    end

  assign o_out_valid = (r_state == FULL);
  assign o_out_data  = r_data;
  assign o_out_id    = r_id;
  assign o_conv_cnt  = r_cnt;
endmodule

// File: tb/tb_fp16_to_fp32_rr_arbiter.sv
// tb_fp16_to_fp32_rr_arbiter: directed stimulus checked every cycle against a value-level
// model of the shared converter, plus literal expectations at key points.
module tb_fp16_to_fp32_rr_arbiter;
  logic        clk, rst, out_ready;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic [3:0]  conv_cnt;
  int checks = 0;
  int failures = 0;

  fp16_to_fp32_rr_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_out_valid(out_valid), .o_out_data(out_data),
    .o_out_id(out_id), .i_out_ready(out_ready), .o_conv_cnt(conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // value-level conversion: build the real number, then repack it as single precision
  function automatic logic [31:0] model_conv(input logic [15:0] h);
    int ei, mi, ex;
    real r;
    logic [63:0] b;
    ei = int'(h[14:10]);
    mi = int'(h[9:0]);
    if (ei == 31) return {h[15], 8'hFF, h[9:0], 13'b0};
    if (ei == 0 && mi == 0) return {h[15], 31'b0};
    r = (ei == 0) ? mi * (2.0 ** -24.0) : (1.0 + mi / 1024.0) * (2.0 ** real'(ei - 15));
    b = $realtobits(r);
    ex = int'(b[62:52]) - 1023 + 127;
    return {h[15], ex[7:0], b[51:29]};
  endfunction

  logic        m_full;
  logic [31:0] m_data;
  logic [1:0]  m_id;
  int          m_last;
  logic [3:0]  m_cnt;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = pick(req_valid, m_last);
    if (rst || (m_full && !out_ready) || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic logic [15:0] sel_data(input int g);
    return req_data[16*g +: 16];
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_id   <= '0;
      m_last <= 3;
      m_cnt  <= '0;
    end else begin
      if (m_full && out_ready) m_cnt <= m_cnt + 4'd1;
      if (exp_ready() != 4'b0) begin
        m_full <= 1'b1;
        m_data <= model_conv(sel_data(pick(req_valid, m_last)));
        m_id   <= 2'(pick(req_valid, m_last));
        m_last <= pick(req_valid, m_last);
      end else if (out_ready) m_full <= 1'b0;
    end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data", out_data, m_data);
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sp_in [4] = '{16'h8000, 16'h0001, 16'h7C00, 16'hC000};
  logic [31:0] sp_out[4] = '{32'h80000000, 32'h33800000, 32'h7F800000, 32'hC0000000};
  logic [31:0] keep_d;
  logic [1:0]  keep_i;

  initial begin
    clk = 0; rst = 0; req_valid = 0; req_data = 0; out_ready = 1;
    #2 rst = 1;
    step(); step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", 32'(conv_cnt), 0);
    rst = 0;
    // single request
    req_valid = 4'b0001; req_data[15:0] = 16'h3C00;
    #1 chk("t1_ready", 32'(req_ready), 1);
    step(); req_valid = 0;
    #1 chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", out_data, 32'h3F800000);
    chk("t1_id", 32'(out_id), 0);
    step();
    #1 chk("t1_cnt", 32'(conv_cnt), 1);
    // special values from requester 1
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      req_data[31:16] = sp_in[i];
      step();
      #1 chk("sp_data", out_data, sp_out[i]);
      chk("sp_id", 32'(out_id), 1);
    end
    req_valid = 0; step();
    // prime last grant on requester 3, then all four requesting
    req_data = {16'h4800, 16'h4400, 16'h4000, 16'h3C00};
    req_valid = 4'b1000; step();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      #1 chk("rr_id", 32'(out_id), 32'(k % 4));
    end
    // backpressure for three edges
    out_ready = 0;
    #1 chk("bp_ready0", 32'(req_ready), 0);
    keep_d = out_data; keep_i = out_id;
    for (int k = 0; k < 3; k++) begin
      step();
      #1 chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", out_data, keep_d);
      chk("bp_id", 32'(out_id), 32'(keep_i));
    end
    chk("bp_id3", 32'(keep_i), 3);
    out_ready = 1;
    #1 chk("bp_release", 32'(req_ready), 1);
    step();
    #1 chk("bp_next_id", 32'(out_id), 0);
    req_valid = 0; step(); step();
    // reset during a stall
    req_data[15:0] = 16'h4000; req_data[31:16] = 16'h3C00;
    req_valid = 4'b0001; out_ready = 0; step();
    req_valid = 0; step();
    #1 chk("rs_full", 32'(out_valid), 1);
    rst = 1;
    #1 chk("rs_valid", 32'(out_valid), 0);
    chk("rs_data", out_data, 0);
    req_valid = 4'b1010; out_ready = 1;
    #1 chk("rs_noready", 32'(req_ready), 0);
    step(); step();
    rst = 0;
    #1 chk("rs_first", 32'(req_ready), 32'b0010);
    step();
    #1 chk("rs_id", 32'(out_id), 1);
    chk("rs_out", out_data, 32'h3F800000);
    req_valid = 0; step();
    // counter wrap with a 4-bit counter
    rst = 1; step(); rst = 0;
    req_valid = 4'b0001;
    repeat (17) step();
    req_valid = 0; step();
    #1 chk("wrap_cnt", 32'(conv_cnt), 1);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
